// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one combinational 4-bit ALU among NREQ requesters.
// Defining ALU_ARB_STATS_EN adds the stat_ops completed-response counter port.
module alu_req_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [4*NREQ-1:0] req_a,
   input  logic [4*NREQ-1:0] req_b,
   input  logic [3*NREQ-1:0] req_op,
   output logic [3:0]        alu_a,
   output logic [3:0]        alu_b,
   output logic [2:0]        alu_op,
   input  logic [3:0]        alu_result,
   input  logic              alu_carry,
   input  logic              alu_zero,
   input  logic              alu_negative,
   input  logic              alu_overflow,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [3:0]        rsp_result,
   output logic [3:0]        rsp_flags
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [15:0]       stat_ops
`endif
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t         state_reg, state_next;
   logic [IDW-1:0] last_reg;
   logic [IDW-1:0] id_reg;
   logic [3:0]     a_reg, b_reg;
   logic [2:0]     op_reg;
   logic           rsp_valid_reg;
   logic [3:0]     rsp_result_reg, rsp_flags_reg;

   logic [3:0]     a_arr  [NREQ];
   logic [3:0]     b_arr  [NREQ];
   logic [2:0]     op_arr [NREQ];

   logic           grant_any;
   logic [IDW-1:0] grant_idx;
   logic [IDW-1:0] cand;
   logic           accept;
   logic           rsp_fire;

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign a_arr[gi]  = req_a[4*gi +: 4];
         assign b_arr[gi]  = req_b[4*gi +: 4];
         assign op_arr[gi] = req_op[3*gi +: 3];
      end
   endgenerate

   // Scan offsets from the farthest down to last+1 so the nearest requester after last wins.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = last_reg;
      cand      = '0;
      for (int k = NREQ; k >= 1; k--) begin
         cand = IDW'((int'(last_reg) + k) % NREQ);
         if (req_valid[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end
      end
   end

   assign accept   = (state_reg == IDLE) && grant_any;
   assign rsp_fire = rsp_valid_reg && rsp_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (grant_any) state_next = EXEC;
         EXEC:    state_next = RESP;
         RESP:    if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Grant is withheld while reset is asserted so no requester sees a phantom accept.
   always_comb begin
      req_ready = '0;
      if (rst_n && accept) req_ready[grant_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_reg <= IDW'(NREQ - 1);
         id_reg   <= '0;
         a_reg    <= '0;
         b_reg    <= '0;
         op_reg   <= '0;
      end else if (accept) begin
         last_reg <= grant_idx;
         id_reg   <= grant_idx;
         a_reg    <= a_arr[grant_idx];
         b_reg    <= b_arr[grant_idx];
         op_reg   <= op_arr[grant_idx];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_reg  <= 1'b0;
         rsp_result_reg <= '0;
         rsp_flags_reg  <= '0;
      end else if (state_reg == EXEC) begin
         rsp_valid_reg  <= 1'b1;
         rsp_result_reg <= alu_result;
         rsp_flags_reg  <= {alu_carry, alu_zero, alu_negative, alu_overflow};
      end else if (rsp_fire) begin
         rsp_valid_reg  <= 1'b0;
      end
   end

   assign alu_a      = a_reg;
   assign alu_b      = b_reg;
   assign alu_op     = op_reg;
   assign rsp_valid  = rsp_valid_reg;
   assign rsp_id     = id_reg;
   assign rsp_result = rsp_result_reg;
   assign rsp_flags  = rsp_flags_reg;

`ifdef ALU_ARB_STATS_EN
   logic [15:0] stat_ops_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                  stat_ops_reg <= '0;
      else if (rsp_fire && stat_ops_reg != 16'hFFFF) stat_ops_reg <= stat_ops_reg + 16'd1;
   end

   assign stat_ops = stat_ops_reg;
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter: behavioural ALU, response scoreboard, directed scenarios.
module tb_alu_req_arbiter;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid, req_ready;
   logic [4*NREQ-1:0] req_a, req_b;
   logic [3*NREQ-1:0] req_op;
   logic [3:0]        alu_a, alu_b, alu_result;
   logic [2:0]        alu_op;
   logic              alu_carry, alu_zero, alu_negative, alu_overflow;
   logic              rsp_valid, rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [3:0]        rsp_result, rsp_flags;
`ifdef ALU_ARB_STATS_EN
   logic [15:0]       stat_ops;
`endif

   int n_checks = 0;
   int n_errors = 0;
   logic [IDW+7:0] exp_q [$];
   int grant_log [$];
   int rsp_cnt = 0;

   always #5 clk = ~clk;

   alu_req_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
      .alu_negative(alu_negative), .alu_overflow(alu_overflow),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_flags(rsp_flags)
`ifdef ALU_ARB_STATS_EN
      , .stat_ops(stat_ops)
`endif
   );

   // Reference ALU: returns {result, carry, zero, negative, overflow}.
   function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
      logic [4:0] s;
      logic [3:0] r;
      logic c, v;
      s = '0; c = 1'b0; v = 1'b0;
      case (op)
         3'd0: begin s = {1'b0, a} + {1'b0, b}; c = s[4]; v = (a[3] == b[3]) && (s[3] != a[3]); end
         3'd1: begin s = {1'b0, a} - {1'b0, b}; c = s[4]; v = (a[3] != b[3]) && (s[3] != a[3]); end
         3'd2: s = {1'b0, a & b};
         3'd3: s = {1'b0, a | b};
         3'd4: s = {1'b0, a ^ b};
         3'd5: s = {1'b0, ~a};
         3'd6: begin s = {a, 1'b0}; c = a[3]; end
         default: begin s = {2'b00, a[3:1]}; c = a[0]; end
      endcase
      r = s[3:0];
      return {r, c, (r == 4'd0), r[3], v};
   endfunction

   assign {alu_result, alu_carry, alu_zero, alu_negative, alu_overflow} = alu_f(alu_a, alu_b, alu_op);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard: push expectation at grant, pop and compare at response handshake.
   always @(negedge clk) begin : mon
      int id;
      logic [IDW+7:0] e;
      logic [7:0] r;
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         if (req_ready != '0) begin
            id = 0;
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) id = i;
            check("ready_onehot", 32'($onehot(req_ready)), 1);
            check("ready_has_valid", 32'(req_valid[id]), 1);
            r = alu_f(req_a[4*id +: 4], req_b[4*id +: 4], req_op[3*id +: 3]);
            exp_q.push_back({IDW'(id), r});
            grant_log.push_back(id);
         end
         if (rsp_valid && rsp_ready) begin
            $display("rsp id=%0d result=%h flags=%b", rsp_id, rsp_result, rsp_flags);
            if (exp_q.size() == 0) begin
               check("rsp_unexpected", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("rsp_id", 32'(rsp_id), 32'(e[IDW+7:8]));
               check("rsp_result", 32'(rsp_result), 32'(e[7:4]));
               check("rsp_flags", 32'(rsp_flags), 32'(e[3:0]));
            end
            rsp_cnt++;
         end
      end
   end

   task automatic set_req(input int id, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
      req_a[4*id +: 4]  = a;
      req_b[4*id +: 4]  = b;
      req_op[3*id +: 3] = op;
   endtask

   // Returns at the negedge where a grant is visible; gid = -1 on timeout.
   task automatic wait_grant(output int gid);
      gid = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (req_ready != '0) begin
            for (int j = 0; j < NREQ; j++) if (req_ready[j]) gid = j;
            break;
         end
      end
      if (gid < 0) check("grant_timeout", 0, 1);
   endtask

   task automatic drain();
      int ok;
      ok = 0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk); #1;
         if (exp_q.size() == 0 && !rsp_valid) begin ok = 1; break; end
      end
      check("drain_timeout", 32'(ok), 1);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Single request from id; returns just after the accept edge with req_valid dropped.
   task automatic run_op(input int id, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op, output int gid);
      set_req(id, a, b, op);
      req_valid = '0;
      req_valid[id] = 1'b1;
      wait_grant(gid);
      @(posedge clk); #1;
      req_valid = '0;
   endtask

   initial begin
      int gid, base;
      rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_req_ready", 32'(req_ready), 0);
      check("rst_alu_a", 32'(alu_a), 0);
      check("rst_alu_b", 32'(alu_b), 0);
      check("rst_alu_op", 32'(alu_op), 0);
      check("rst_rsp_id", 32'(rsp_id), 0);
      check("rst_rsp_result", 32'(rsp_result), 0);
      check("rst_rsp_flags", 32'(rsp_flags), 0);
`ifdef ALU_ARB_STATS_EN
      check("rst_stat_ops", 32'(stat_ops), 0);
`endif
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Lone requester 2: 7 + 1
      rsp_ready = 1'b1;
      run_op(2, 4'd7, 4'd1, 3'd0, gid);
      check("t1_grant", 32'(gid), 2);
      @(negedge clk);
      check("t1_ready_pulse", 32'(req_ready), 0);
      check("t1_alu_a", 32'(alu_a), 7);
      check("t1_alu_b", 32'(alu_b), 1);
      check("t1_alu_op", 32'(alu_op), 0);
      check("t1_rsp_early", 32'(rsp_valid), 0);
      @(negedge clk);
      check("t1_rsp_valid", 32'(rsp_valid), 1);
      check("t1_rsp_id", 32'(rsp_id), 2);
      check("t1_rsp_result", 32'(rsp_result), 4'b1000);
      check("t1_rsp_flags", 32'(rsp_flags), 4'b0011);
      drain();

      // All four requesting from a fresh pointer
      do_reset();
      for (int i = 0; i < NREQ; i++)
         set_req(i, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
      base = grant_log.size();
      req_valid = '1;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (grant_log.size() >= base + 6) break;
      end
      req_valid = '0;
      check("t2_grant_count", 32'(grant_log.size() - base), 6);
      for (int k = 0; k < 6; k++)
         if (base + k < grant_log.size()) check("t2_order", 32'(grant_log[base+k]), 32'(k % NREQ));
      drain();

      // Backpressure after a grant to requester 1
      rsp_ready = 1'b0;
      set_req(0, 4'd2, 4'd2, 3'd1);
      set_req(3, 4'd9, 4'd4, 3'd4);
      run_op(1, 4'd3, 4'd2, 3'd0, gid);
      check("t3_grant", 32'(gid), 1);
      req_valid = 4'b1001;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t3_hold_valid", 32'(rsp_valid), 1);
         check("t3_hold_id", 32'(rsp_id), 1);
         check("t3_hold_result", 32'(rsp_result), 5);
         check("t3_hold_flags", 32'(rsp_flags), 0);
         check("t3_no_grant", 32'(req_ready), 0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      wait_grant(gid);
      check("t3_next_grant", 32'(gid), 3);
      @(posedge clk); #1;
      req_valid = 4'b0001;
      wait_grant(gid);
      check("t3_wrap_grant", 32'(gid), 0);
      @(posedge clk); #1;
      req_valid = '0;
      drain();

      // 15 + 1 wraps to zero with carry
      run_op(0, 4'hF, 4'h1, 3'd0, gid);
      @(negedge clk);
      @(negedge clk);
      check("t4_rsp_valid", 32'(rsp_valid), 1);
      check("t4_result", 32'(rsp_result), 0);
      check("t4_flags", 32'(rsp_flags), 4'b1100);
      drain();

      // Reset during EXEC abandons the operation
      req_valid = '1;
      wait_grant(gid);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("t5_rsp_valid", 32'(rsp_valid), 0);
      check("t5_alu_a", 32'(alu_a), 0);
      check("t5_req_ready", 32'(req_ready), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t5_no_rsp", 32'(rsp_valid), 0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      base = rsp_cnt;
      wait_grant(gid);
      check("t5_first_grant", 32'(gid), 0);
      @(posedge clk); #1;
      req_valid = '0;
      drain();
      check("t5_one_rsp", 32'(rsp_cnt - base), 1);

      // Three completed operations, then reset
      do_reset();
`ifdef ALU_ARB_STATS_EN
      check("t6_stat_zero", 32'(stat_ops), 0);
`endif
      for (int i = 0; i < 3; i++) begin
         run_op(i, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), gid);
         check("t6_grant", 32'(gid), 32'(i));
         drain();
      end
`ifdef ALU_ARB_STATS_EN
      check("t6_stat_three", 32'(stat_ops), 3);
      do_reset();
      #1;
      check("t6_stat_reset", 32'(stat_ops), 0);
`endif

      check("sb_empty", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares one combinational 4-bit ALU between NREQ requesters using round-robin arbitration.
- Registers the winning operands and drives them to the ALU, then captures the ALU result and flags.
- Returns the captured result to the winner, tagged with its requester index, over a valid/ready response channel.
- Sits between the requester blocks and the ALU instance; the ALU monitor taps the ALU-side nets unchanged.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), width of the response requester-id field.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  4*NREQ  operand A; requester i uses bits [4i+3:4i].
- req_b  in  4*NREQ  operand B; same packing as req_a.
- req_op  in  3*NREQ  opcode; requester i uses bits [3i+2:3i].
- alu_a  out  4  operand A to the ALU.
- alu_b  out  4  operand B to the ALU.
- alu_op  out  3  opcode to the ALU.
- alu_result  in  4  ALU result.
- alu_carry, alu_zero, alu_negative, alu_overflow  in  1 each  ALU flags.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_result  out  4  captured result.
- rsp_flags  out  4  captured flags, {carry, zero, negative, overflow}.

Behaviour:
- The clock port is clk. Reset rst_n is asynchronous, active-low, single clock domain.
- FSM states: IDLE, EXEC, RESP.
- Reset values:
  - state = IDLE.
  - alu_a, alu_b, alu_op = 0.
  - rsp_valid = 0; rsp_id, rsp_result, rsp_flags = 0.
  - Round-robin pointer last = NREQ-1, so requester 0 has first priority.
  - req_ready = 0.
- IDLE:
  - req_ready[g] = 1 combinationally for the winner g: the first i with req_valid[i], searching from last+1 upward and wrapping.
  - All other req_ready bits = 0.
  - On the clock edge with any req_valid set:
    - latch req_a[g], req_b[g], req_op[g] into the operand registers (these drive alu_a, alu_b, alu_op);
    - latch g into the id register;
    - set last = g;
    - go to EXEC.
  - With no requests, stay in IDLE and hold the operand registers.
- EXEC (exactly one cycle):
  - req_ready = 0.
  - ALU inputs are stable from the registers.
  - At the end of the cycle, capture alu_result and the four flags into the rsp registers, set rsp_valid = 1, and go to RESP.
- RESP:
  - rsp_valid = 1. rsp_id, rsp_result and rsp_flags are held stable until rsp_valid && rsp_ready.
  - On that edge: rsp_valid = 0, go to IDLE.
  - No new grant is issued while in RESP (backpressure stalls arbitration).
- Latency: the accept edge is E0, the capture edge is E0+1, and rsp_valid is high in the cycle after E0+1.
  - Minimum issue interval is 3 cycles per operation when rsp_ready is held high.
- Requester rules:
  - Hold req_valid and the operands stable until req_ready is seen.
  - req_ready may depend combinationally on req_valid. req_valid must not depend on req_ready.
  - A requester that retracts req_valid before it is granted is simply not granted; no error is raised.
- Fairness: with all NREQ requesting continuously, grants go 0,1,...,NREQ-1,0,... A lone requester is granted on every pass through IDLE.
- Flags and result pass through unmodified. Every 3-bit opcode is forwarded; opcode semantics belong to the ALU.
- rst_n asserted in any state:
  - immediately returns the block to reset values;
  - abandons any in-flight transaction with no response issued;
  - restarts the pointer at requester 0.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- When defined, the block adds an output port stat_ops (16 bits, reset 0).
  - It increments by 1 on each completed response handshake (rsp_valid && rsp_ready).
  - It saturates at 16'hFFFF.
- When not defined, the port and the counter are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, then only req_valid[2] with a=4'b0111, b=4'b0001, op=ADD and rsp_ready=1:
  - req_ready[2] pulses for 1 cycle;
  - alu_a=7, alu_b=1 on the next cycle;
  - response has rsp_id=2, rsp_result=4'b1000, flags {0,0,1,1}.
- All 4 requesters hold req_valid, rsp_ready=1 → grant order 0,1,2,3,0,1, and each rsp_id matches its grant.
- After a grant to requester 1, hold rsp_ready=0 for 5 cycles:
  - rsp_valid stays high and rsp_* outputs stay stable;
  - req_ready stays 0 throughout;
  - after rsp_ready=1, the next grant goes to the next pending index after 1.
- a=4'b1111, b=4'b0001, op=ADD → rsp_result=0, carry=1, zero=1, both captured from the ALU unchanged.
- Assert rst_n=0 during EXEC → rsp_valid=0 immediately and no response follows; after release, requester 0 wins if all requesters are requesting.
- With ALU_ARB_STATS_EN, complete 3 operations → stat_ops=3; after reset, stat_ops=0.
